fifo_sync_param: RTL



---
 rtl/fifo_sync_pkg.sv | 17 +
 rtl/fifo_sync_param_if.sv | 35 +++
 rtl/fifo_sync_ram.sv | 44 ++++
 rtl/fifo_sync_param.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fifo_sync_pkg.sv
// Shared sizing helpers and default parameters for the parametrised synchronous FIFO.
package fifo_sync_pkg;

    localparam int unsigned DataWDefault = 8;
    localparam int unsigned DepthDefault = 16;

    // Pointer width: DEPTH is a power of two, so pointers wrap naturally.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width: one extra bit so the count can hold DEPTH itself.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return ptr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle for fifo_sync_param; the FIFO sits on the slave modport.
interface fifo_sync_param_if
    import fifo_sync_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned DEPTH  = DepthDefault
);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic              wr;
    logic [DATA_W-1:0] din;
    logic              rd;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr, din, rd,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               fifo_cnt, overflow, underflow
    );

    modport slave (
        input  wr, din, rd,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               fifo_cnt, overflow, underflow
    );

endinterface

// File: rtl/fifo_sync_ram.sv
// DEPTH x DATA_W storage with one write port and one read port offering both a
// combinational and a registered read-data output. Contents are never reset.
module fifo_sync_ram
    import fifo_sync_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned DEPTH  = DepthDefault,
    parameter int unsigned ADDR_W = ptr_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] rdata_q_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage write; no reset so the array maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

    // Registered read port; holds its value when no read is issued.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rdata_o;
        end
    end

    assign rdata_q_o = rdata_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty levels
// and sticky overflow/underflow flags. Define FIFO_SYNC_FWFT_EN for
// first-word-fall-through output; otherwise reads have one cycle of latency.
module fifo_sync_param
    import fifo_sync_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned DEPTH  = DepthDefault,
    parameter int unsigned AF_LVL = DEPTH - 2,
    parameter int unsigned AE_LVL = 2
) (
    input logic               clk,
    input logic               reset_n,
    fifo_sync_param_if.slave  bus
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             rd_en, wr_en;
    logic [DATA_W-1:0] rdata_comb, rdata_reg;

    assign rd_en = bus.rd & ~empty_q;
    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign wr_en = bus.wr & (~full_q | rd_en);

    // Next-state for pointers, occupancy, status and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == CNT_W'(DEPTH));
        empty_d = (cnt_d == '0);
        af_d    = (cnt_d >= CNT_W'(AF_LVL));
        ae_d    = (cnt_d <= CNT_W'(AE_LVL));
        ovf_d   = ovf_q | (bus.wr & ~wr_en);
        unf_d   = unf_q | (bus.rd & empty_q);
    end

    // State registers; reset values match an empty FIFO.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Gate with reset_n so an access during reset never touches storage.
    fifo_sync_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk_i     (clk),
        .reset_ni  (reset_n),
        .we_i      (wr_en & reset_n),
        .waddr_i   (wr_ptr_q),
        .wdata_i   (bus.din),
        .re_i      (rd_en & reset_n),
        .raddr_i   (rd_ptr_q),
        .rdata_o   (rdata_comb),
        .rdata_q_o (rdata_reg)
    );

`ifdef FIFO_SYNC_FWFT_EN
    logic [DATA_W-1:0] rdata_reg_unused;
    assign rdata_reg_unused = rdata_reg;

    // Head of queue is always presented; zero while empty.
    assign bus.dout       = empty_q ? '0 : rdata_comb;
    assign bus.dout_valid = ~empty_q;
`else
    logic              dvalid_q;
    logic [DATA_W-1:0] rdata_comb_unused;
    assign rdata_comb_unused = rdata_comb;

    // Valid strobe marks the single cycle after each accepted pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dvalid_q <= 1'b0;
        end else begin
            dvalid_q <= rd_en;
        end
    end

    assign bus.dout       = rdata_reg;
    assign bus.dout_valid = dvalid_q;
`endif

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.fifo_cnt     = cnt_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule
